// File: rtl/sample_pkg.sv
// Shared types and constants for the serial sample path.
// Holds the framing FSM state encoding and the line levels used by the serializer.
package sample_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam int   DEFAULT_DW  = 4;
    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/bit_timer.sv
// Paces serial bit periods: pulses bit_tick on the last clock of each bit.
// Held at zero while restart is high so every frame begins on a fresh bit period.
module bit_timer #(
    parameter int CLKS_PER_BIT = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic bit_tick
);

    localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] clk_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_cnt <= '0;
        end else if (restart || (clk_cnt == LAST)) begin
            clk_cnt <= '0;
        end else begin
            clk_cnt <= clk_cnt + CW'(1);
        end
    end

    assign bit_tick = !restart && (clk_cnt == LAST);

endmodule

// File: rtl/sample_serializer.sv
// Framed serial transmitter: start bit, DW data bits LSB-first, optional even parity, stop bit.
// Outputs are registered from the next-state decode so they change on the same edge as the FSM.
module sample_serializer
    import sample_pkg::*;
#(
    parameter int DW           = DEFAULT_DW,
    parameter int CLKS_PER_BIT = 2,
    parameter int PARITY_EN    = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] din,
    input  logic          din_valid,
    output logic          din_ready,
    output logic          sdo,
    output logic          sdo_en,
    output logic          done
);

    localparam int            BW       = $clog2(DW + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DW - 1);

    state_t        state, state_next;
    logic [DW-1:0] shreg, shreg_next;
    logic [BW-1:0] bit_cnt, bit_cnt_next;
    logic          parity, parity_next;
    logic          sdo_next, sdo_en_next, din_ready_next, done_next;
    logic          bit_tick;

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (state == IDLE),
        .bit_tick(bit_tick)
    );

    always_comb begin
        state_next   = state;
        shreg_next   = shreg;
        bit_cnt_next = bit_cnt;
        parity_next  = parity;
        done_next    = 1'b0;

        case (state)
            IDLE: begin
                if (din_valid) begin
                    state_next   = START;
                    shreg_next   = din;
                    parity_next  = ^din;
                    bit_cnt_next = '0;
                end
            end
            START: begin
                if (bit_tick) state_next = DATA;
            end
            DATA: begin
                if (bit_tick) begin
                    shreg_next = shreg >> 1;
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt_next = '0;
                        state_next   = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_cnt_next = bit_cnt + BW'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_tick) state_next = STOP;
            end
            STOP: begin
                if (bit_tick) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        // Line level follows the state being entered, so sdo lines up with the FSM edge.
        case (state_next)
            START:   sdo_next = START_LEVEL;
            DATA:    sdo_next = shreg_next[0];
            PARITY:  sdo_next = parity_next;
            default: sdo_next = IDLE_LEVEL;
        endcase
        sdo_en_next    = (state_next != IDLE);
        din_ready_next = (state_next == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            parity    <= 1'b0;
            sdo       <= IDLE_LEVEL;
            sdo_en    <= 1'b0;
            din_ready <= 1'b1;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            shreg     <= shreg_next;
            bit_cnt   <= bit_cnt_next;
            parity    <= parity_next;
            sdo       <= sdo_next;
            sdo_en    <= sdo_en_next;
            din_ready <= din_ready_next;
            done      <= done_next;
        end
    end

endmodule

// File: tb/tb_sample_serializer.sv
// Scoreboard bench for sample_serializer: lane 0 uses DW=4/CLKS_PER_BIT=2/no parity,
// lane 1 uses DW=4/CLKS_PER_BIT=1/even parity; both are checked cycle by cycle.
module tb_sample_serializer;

    localparam int DW = 4;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] din       [2];
    logic          din_valid [2];
    logic          din_ready [2];
    logic          sdo       [2];
    logic          sdo_en    [2];
    logic          done      [2];

    int checks = 0;
    int errors = 0;

    always #10 clk = ~clk;

    task automatic checkOutput(input string name, input int lane, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s lane%0d: got %b, expected %b at %0t", name, lane, got, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : lane_g
        localparam int CPB       = (g == 0) ? 2 : 1;
        localparam int PEN       = (g == 0) ? 0 : 1;
        localparam int FRAME_LEN = (DW + 2 + PEN) * CPB;

        logic [DW-1:0] word_q  [$];
        logic          level_q [$];
        int            busy      = 0;
        logic          post_done = 1'b0;

        sample_serializer #(
            .DW          (DW),
            .CLKS_PER_BIT(CPB),
            .PARITY_EN   (PEN)
        ) dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .din      (din[g]),
            .din_valid(din_valid[g]),
            .din_ready(din_ready[g]),
            .sdo      (sdo[g]),
            .sdo_en   (sdo_en[g]),
            .done     (done[g])
        );

        // Reference: a word is taken whenever the line has been free for a full frame plus gap.
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                busy <= 0;
                word_q.delete();
            end else if (busy == 0) begin
                if (din_valid[g]) begin
                    word_q.push_back(din[g]);
                    busy <= FRAME_LEN;
                end
            end else begin
                busy <= busy - 1;
            end
        end

        task automatic loadFrame(input logic [DW-1:0] w);
            repeat (CPB) level_q.push_back(1'b0);
            for (int i = 0; i < DW; i++) begin
                repeat (CPB) level_q.push_back(w[i]);
            end
            if (PEN != 0) begin
                repeat (CPB) level_q.push_back(1'(($countones(w) % 2)));
            end
            repeat (CPB) level_q.push_back(1'b1);
        endtask

        // Monitor: consumes one expected line level per cycle while a frame is owed.
        always @(negedge clk) begin
            if (!rst_n) begin
                level_q.delete();
                post_done <= 1'b0;
            end else if (post_done) begin
                checkOutput("done_pulse", g, done[g], 1'b1);
                checkOutput("ready_after_frame", g, din_ready[g], 1'b1);
                checkOutput("sdo_en_after_frame", g, sdo_en[g], 1'b0);
                checkOutput("sdo_after_frame", g, sdo[g], 1'b1);
                post_done <= 1'b0;
            end else if (level_q.size() == 0 && word_q.size() == 0) begin
                checkOutput("idle_sdo", g, sdo[g], 1'b1);
                checkOutput("idle_sdo_en", g, sdo_en[g], 1'b0);
                checkOutput("idle_ready", g, din_ready[g], 1'b1);
                checkOutput("idle_done", g, done[g], 1'b0);
            end else begin
                if (level_q.size() == 0) loadFrame(word_q.pop_front());
                checkOutput("frame_sdo", g, sdo[g], level_q.pop_front());
                checkOutput("frame_sdo_en", g, sdo_en[g], 1'b1);
                checkOutput("frame_ready", g, din_ready[g], 1'b0);
                checkOutput("frame_done", g, done[g], 1'b0);
                if (level_q.size() == 0) post_done <= 1'b1;
            end
        end
    end

    task automatic applyStimulus(input int lane, input logic [DW-1:0] word, input int cycles);
        @(posedge clk);
        #2;
        din[lane]       = word;
        din_valid[lane] = 1'b1;
        repeat (cycles) @(posedge clk);
        #2;
        din_valid[lane] = 1'b0;
    endtask

    task automatic holdUntilAccepted(input int lane);
        int n = 0;
        while (!din_ready[lane] && n < 200) begin
            @(posedge clk);
            #2;
            n++;
        end
        checkOutput("ready_timeout", lane, din_ready[lane], 1'b1);
        @(posedge clk);
        #2;
        din_valid[lane] = 1'b0;
    endtask

    task automatic waitIdle(input int lane);
        int n = 0;
        @(posedge clk);
        #2;
        while (!din_ready[lane] && n < 200) begin
            @(posedge clk);
            #2;
            n++;
        end
        checkOutput("idle_timeout", lane, din_ready[lane], 1'b1);
        repeat (3) @(posedge clk);
        #2;
    endtask

    task automatic randLane(input int lane, input int frames);
        for (int i = 0; i < frames; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            applyStimulus(lane, 4'($urandom), int'($urandom_range(1, 20)));
        end
    endtask

    initial begin
        for (int l = 0; l < 2; l++) begin
            din[l]       = '0;
            din_valid[l] = 1'b0;
        end

        // Reset values while rst_n is held low
        #15;
        for (int l = 0; l < 2; l++) begin
            checkOutput("reset_sdo", l, sdo[l], 1'b1);
            checkOutput("reset_sdo_en", l, sdo_en[l], 1'b0);
            checkOutput("reset_ready", l, din_ready[l], 1'b1);
            checkOutput("reset_done", l, done[l], 1'b0);
        end
        #10 rst_n = 1'b1;

        // Single frame
        applyStimulus(0, 4'b0101, 1);
        waitIdle(0);

        // Back-to-back frames with din_valid held across the gap
        @(posedge clk);
        #2;
        din[0]       = 4'b0101;
        din_valid[0] = 1'b1;
        @(posedge clk);
        #2;
        din[0] = 4'b1010;
        holdUntilAccepted(0);
        waitIdle(0);

        // Input changes mid-frame must not disturb the captured word
        applyStimulus(0, 4'b0101, 1);
        repeat (4) @(posedge clk);
        #2;
        din[0]       = 4'b1111;
        din_valid[0] = 1'b1;
        holdUntilAccepted(0);
        waitIdle(0);

        // Reset during DATA abandons the frame immediately
        applyStimulus(0, 4'b0011, 1);
        repeat (4) @(posedge clk);
        #5;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_sdo", 0, sdo[0], 1'b1);
        checkOutput("midreset_sdo_en", 0, sdo_en[0], 1'b0);
        checkOutput("midreset_ready", 0, din_ready[0], 1'b1);
        checkOutput("midreset_done", 0, done[0], 1'b0);
        #20 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #2;

        // Parity lane, one clock per bit
        applyStimulus(1, 4'b0111, 1);
        waitIdle(1);

        // Randomized traffic on both lanes concurrently
        fork
            randLane(0, 40);
            randLane(1, 40);
        join
        waitIdle(0);
        waitIdle(1);
        repeat (5) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
